// File: rtl/cl_timing_ctrl.sv
// cl_timing_ctrl -- CameraLink frame/line timing controller.
//
// Paces a pixel source into CameraLink Fval/Lval/Dval framing. A frame is
// SETUP (Fval high, no lines), then imageHeight lines of imageWidth/PIX_PER_TAP
// beats separated by HBLANK gaps, then a VBLANK gap. Geometry is latched at
// every frame start so it can be reprogrammed while a frame is in flight.
//
// Optional feature: define CL_UNDERRUN_CNT_EN to build the underrun counter
// (LINE cycles with no source data, saturating, cleared at each frame start).
// Without the macro underrun_cnt is tied to zero and no counter is built.
module cl_timing_ctrl #(
  parameter int PIX_PER_TAP = 2,
  parameter int CW          = 16
) (
  input  logic          pixel_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic          stop,
  input  logic          cont_mode,
  input  logic [CW-1:0] imageWidth,
  input  logic [CW-1:0] imageHeight,
  input  logic [CW-1:0] hblank,
  input  logic [CW-1:0] vblank,
  input  logic [7:0]    fv_setup,
  input  logic          src_valid,
  output logic          pix_rdy,
  output logic          Fval,
  output logic          Lval,
  output logic          Dval,
  output logic [CW-1:0] frame_cnt,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err,
  output logic [CW-1:0] underrun_cnt
);

  // Beats per line is a plain right shift; legal tap counts are 1, 2 and 4.
  localparam int TAP_SHIFT = (PIX_PER_TAP == 4) ? 2 :
                             (PIX_PER_TAP == 2) ? 1 : 0;

  // The phase counter times SETUP (8-bit fv_setup) as well as the CW-wide
  // blanking intervals, so it must be wide enough for both.
  localparam int PW = (CW > 8) ? CW : 8;

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [CW-1:0] C_TAPS = CW'(PIX_PER_TAP);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_LINE   = 3'd2,
    S_HBLANK = 3'd3,
    S_VBLANK = 3'd4
  } state_t;

  // FSM state and registered outputs
  state_t          r_state;
  logic            r_fval;
  logic            r_lval;
  logic            r_busy;
  logic            r_frame_done;
  logic            r_cfg_err;
  logic            r_stop_pend;
  logic [CW-1:0]   r_frame_cnt;

  // Geometry captured at frame start
  logic [CW-1:0]   r_beats;
  logic [CW-1:0]   r_height;
  logic [CW-1:0]   r_hblank;
  logic [CW-1:0]   r_vblank;
  logic [7:0]      r_fv_setup;

  // Position within the frame
  logic [CW-1:0]   r_beat_idx;
  logic [CW-1:0]   r_line_idx;
  logic [PW-1:0]   r_phase_cnt;

  // Combinational decode
  logic            w_cfg_ok;
  logic            w_accept;
  logic            w_last_beat;
  logic            w_last_line;
  logic            w_phase_done;
  logic            w_stop_req;
  logic            w_restart;
  logic            w_frame_start;

  // A zero-length interval still lasts one cycle: load max(n,1)-1 and count
  // down to zero, leaving the state on the cycle the counter reads zero.
  function automatic logic [PW-1:0] f_phase_load(input logic [PW-1:0] cycles);
    return (cycles == '0) ? '0 : (cycles - P_ONE);
  endfunction

  // A frame needs at least one beat per line and at least one line.
  assign w_cfg_ok     = (imageWidth >= C_TAPS) && (imageHeight != '0);

  // Lval doubles as pix_rdy, so a beat is accepted whenever Lval and the
  // source agree.
  assign w_accept     = r_lval & src_valid;
  assign w_last_beat  = (r_beat_idx == (r_beats - C_ONE));
  assign w_last_line  = (r_line_idx == (r_height - C_ONE));
  assign w_phase_done = (r_phase_cnt == '0);

  // A stop arriving on the last VBLANK cycle must still prevent a restart.
  assign w_stop_req   = r_stop_pend | stop;
  assign w_restart    = (r_state == S_VBLANK) && w_phase_done &&
                        cont_mode && !w_stop_req;

  // Qualifies both the initial start from IDLE and a free-running restart.
  assign w_frame_start = w_cfg_ok &&
                         (((r_state == S_IDLE) && start) || w_restart);

  assign pix_rdy   = r_lval;
  assign Lval      = r_lval;
  assign Fval      = r_fval;
  assign busy      = r_busy;
  assign frame_done = r_frame_done;
  assign cfg_err   = r_cfg_err;
  assign frame_cnt = r_frame_cnt;
  assign Dval      = r_lval & src_valid;

  // Frame sequencer: state, geometry capture, position counters and all
  // registered framing outputs.
  always_ff @(posedge pixel_clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // and every register it touches must appear in the reset arm to avoid
    // holding stale frame state across a mid-frame reset.
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_fval       <= 1'b0;
      r_lval       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_frame_cnt  <= '0;
      r_beats      <= '0;
      r_height     <= '0;
      r_hblank     <= '0;
      r_vblank     <= '0;
      r_fv_setup   <= '0;
      r_beat_idx   <= '0;
      r_line_idx   <= '0;
      r_phase_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments let a later statement in this block
      // override an earlier default for the same register without any
      // ordering hazard between registers.
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;

      if (stop && (r_state != S_IDLE)) begin
        r_stop_pend <= 1'b1;
      end

      if (w_frame_start) begin
        r_beats     <= imageWidth >> TAP_SHIFT;
        r_height    <= imageHeight;
        r_hblank    <= hblank;
        r_vblank    <= vblank;
        r_fv_setup  <= fv_setup;
        r_beat_idx  <= '0;
        r_line_idx  <= '0;
        r_phase_cnt <= f_phase_load(PW'(fv_setup));
        r_state     <= S_SETUP;
        r_fval      <= 1'b1;
        r_lval      <= 1'b0;
        r_busy      <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!w_cfg_ok) begin
              r_cfg_err <= 1'b1;
            end else if (stop) begin
              // start and stop together: run exactly this one frame
              r_stop_pend <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          if (w_phase_done) begin
            r_state <= S_LINE;
            r_lval  <= 1'b1;
          end else begin
            r_phase_cnt <= r_phase_cnt - P_ONE;
          end
        end

        S_LINE: begin
          if (w_accept) begin
            if (w_last_beat) begin
              r_beat_idx <= '0;
              r_lval     <= 1'b0;
              if (w_last_line) begin
                r_state      <= S_VBLANK;
                r_fval       <= 1'b0;
                r_frame_done <= 1'b1;
                r_frame_cnt  <= r_frame_cnt + C_ONE;
                r_phase_cnt  <= f_phase_load(PW'(r_vblank));
              end else begin
                r_state     <= S_HBLANK;
                r_line_idx  <= r_line_idx + C_ONE;
                r_phase_cnt <= f_phase_load(PW'(r_hblank));
              end
            end else begin
              r_beat_idx <= r_beat_idx + C_ONE;
            end
          end
        end

        S_HBLANK: begin
          if (w_phase_done) begin
            r_state <= S_LINE;
            r_lval  <= 1'b1;
          end else begin
            r_phase_cnt <= r_phase_cnt - P_ONE;
          end
        end

        S_VBLANK: begin
          if (w_phase_done) begin
            // A valid restart was already taken by the frame-start path.
            if (!w_frame_start) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_stop_pend <= 1'b0;
              // free-running restart wanted but the new geometry is unusable
              if (w_restart) begin
                r_cfg_err <= 1'b1;
              end
            end
          end else begin
            r_phase_cnt <= r_phase_cnt - P_ONE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_fval      <= 1'b0;
          r_lval      <= 1'b0;
          r_busy      <= 1'b0;
          r_stop_pend <= 1'b0;
        end
      endcase
    end
  end

`ifdef CL_UNDERRUN_CNT_EN
  logic [CW-1:0] r_underrun_cnt;

  // Count LINE cycles starved of source data; saturates, restarts per frame.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      r_underrun_cnt <= '0;
    end else if (w_frame_start) begin
      r_underrun_cnt <= '0;
    end else if ((r_state == S_LINE) && !src_valid && (r_underrun_cnt != '1)) begin
      r_underrun_cnt <= r_underrun_cnt + C_ONE;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_cl_timing_ctrl.sv
// tb_cl_timing_ctrl -- self-checking bench for cl_timing_ctrl.
// The reference model walks each frame phase by phase from the geometry
// (setup length, beats per line, gaps) and the src_valid values it drives.
// A second, narrow instance (CW=4, PIX_PER_TAP=4) exercises frame counter
// wrap-around in a few dozen cycles instead of 65535 frames.
module tb_cl_timing_ctrl;

  localparam int PPT = 2;
  localparam int CW  = 16;

  logic          pixel_clk = 1'b0;
  logic          sys_rst;
  logic          start, stop, cont_mode, src_valid;
  logic [CW-1:0] imageWidth, imageHeight, hblank, vblank;
  logic [7:0]    fv_setup;
  logic          pix_rdy, Fval, Lval, Dval, busy, frame_done, cfg_err;
  logic [CW-1:0] frame_cnt, underrun_cnt;

  logic          b_start, b_stop, b_cont, b_sv;
  logic [3:0]    b_iw, b_ih, b_hb, b_vb;
  logic [7:0]    b_fs;
  logic          b_pix_rdy, b_fval, b_lval, b_dval, b_busy, b_frame_done, b_cfg_err;
  logic [3:0]    b_frame_cnt, b_underrun;

  int            n_cmp = 0;
  int            n_err = 0;
  int            exp_frames = 0;
  int unsigned   g_stall_pct = 0;
  bit            sv_q[$];

  always #5 pixel_clk = ~pixel_clk;

  cl_timing_ctrl #(.PIX_PER_TAP(PPT), .CW(CW)) dut (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
    .cont_mode(cont_mode), .imageWidth(imageWidth), .imageHeight(imageHeight),
    .hblank(hblank), .vblank(vblank), .fv_setup(fv_setup), .src_valid(src_valid),
    .pix_rdy(pix_rdy), .Fval(Fval), .Lval(Lval), .Dval(Dval),
    .frame_cnt(frame_cnt), .busy(busy), .frame_done(frame_done),
    .cfg_err(cfg_err), .underrun_cnt(underrun_cnt)
  );

  cl_timing_ctrl #(.PIX_PER_TAP(4), .CW(4)) dut_w (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst), .start(b_start), .stop(b_stop),
    .cont_mode(b_cont), .imageWidth(b_iw), .imageHeight(b_ih),
    .hblank(b_hb), .vblank(b_vb), .fv_setup(b_fs), .src_valid(b_sv),
    .pix_rdy(b_pix_rdy), .Fval(b_fval), .Lval(b_lval), .Dval(b_dval),
    .frame_cnt(b_frame_cnt), .busy(b_busy), .frame_done(b_frame_done),
    .cfg_err(b_cfg_err), .underrun_cnt(b_underrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge pixel_clk);
    #1;
  endtask

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic pick_sv(output logic v);
    if (sv_q.size() > 0) v = sv_q.pop_front();
    else v = ($urandom_range(99) >= g_stall_pct);
  endtask

  // {Fval, Lval, pix_rdy, Dval, busy, frame_done} against the phase model
  task automatic chk_phase(input string tag, input logic f, input logic l,
                           input logic d, input logic fd);
    check(tag, 32'({Fval, Lval, pix_rdy, Dval, busy, frame_done}),
          32'({f, l, l, d, 1'b1, fd}));
  endtask

  task automatic chk_idle(input string tag);
    check(tag, 32'({Fval, Lval, pix_rdy, Dval, busy, frame_done, cfg_err}), 32'd0);
  endtask

  task automatic scramble_cfg();
    imageWidth  = CW'($urandom);
    imageHeight = CW'($urandom);
    hblank      = CW'($urandom);
    vblank      = CW'($urandom);
    fv_setup    = 8'($urandom);
  endtask

  task automatic start_frame(input int w, input int h, input int hb, input int vb,
                             input int fs, input bit with_stop);
    imageWidth  = CW'(w);
    imageHeight = CW'(h);
    hblank      = CW'(hb);
    vblank      = CW'(vb);
    fv_setup    = 8'(fs);
    src_valid   = 1'b0;
    start       = 1'b1;
    stop        = with_stop;
    next_cycle();
    start       = 1'b0;
    stop        = 1'b0;
  endtask

  // Entered on the first SETUP cycle; returns on the cycle after VBLANK.
  task automatic run_frame(input int w, input int h, input int hb, input int vb,
                           input int fs, input int stop_line, input bit scramble);
    int   beats;
    int   stalls;
    int   acc;
    int   exp_ur;
    bit   stop_sent;
    logic v;
    beats     = w / PPT;
    stalls    = 0;
    stop_sent = 1'b0;
    check("setup_underrun_clear", 32'(underrun_cnt), 32'd0);
    for (int i = 0; i < max1(fs); i++) begin
      src_valid = 1'($urandom);
      if (scramble) scramble_cfg();
      #1;
      chk_phase("setup", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    for (int l = 0; l < h; l++) begin
      acc = 0;
      while (acc < beats) begin
        pick_sv(v);
        src_valid = v;
        if (l == stop_line && !stop_sent) begin
          stop      = 1'b1;
          stop_sent = 1'b1;
        end
        if (scramble) begin
          scramble_cfg();
          start = 1'($urandom);
        end
        #1;
        chk_phase("line", 1'b1, 1'b1, v, 1'b0);
        if (v) acc++;
        else stalls++;
        next_cycle();
        stop  = 1'b0;
        start = 1'b0;
      end
      if (l < h - 1) begin
        for (int j = 0; j < max1(hb); j++) begin
          src_valid = 1'($urandom);
          #1;
          chk_phase("hblank", 1'b1, 1'b0, 1'b0, 1'b0);
          next_cycle();
        end
      end
    end
    exp_frames++;
`ifdef CL_UNDERRUN_CNT_EN
    exp_ur = (stalls > 65535) ? 65535 : stalls;
`else
    exp_ur = 0;
`endif
    for (int j = 0; j < max1(vb); j++) begin
      src_valid = 1'($urandom);
      #1;
      chk_phase("vblank", 1'b0, 1'b0, 1'b0, (j == 0));
      if (j == 0) begin
        check("frame_cnt", 32'(frame_cnt), 32'(exp_frames % 65536));
        check("underrun_cnt", 32'(underrun_cnt), 32'(exp_ur));
      end
      next_cycle();
    end
    src_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    sys_rst = 1'b1; start = 1'b0; stop = 1'b0; cont_mode = 1'b0; src_valid = 1'b0;
    imageWidth = '0; imageHeight = '0; hblank = '0; vblank = '0; fv_setup = '0;
    b_start = 1'b0; b_stop = 1'b0; b_cont = 1'b1; b_sv = 1'b1;
    b_iw = 4'd4; b_ih = 4'd1; b_hb = 4'd0; b_vb = 4'd0; b_fs = 8'd0;
    repeat (3) next_cycle();
    sys_rst = 1'b0;

    // Reset state
    chk_idle("reset_idle");
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    check("reset_underrun", 32'(underrun_cnt), 32'd0);

    // Basic frame: 8 px / 2 taps = 4 beats, 2 lines, gap 1, vblank 3
    g_stall_pct = 0;
    start_frame(8, 2, 1, 3, 1, 1'b0);
    run_frame(8, 2, 1, 3, 1, -1, 1'b0);
    chk_idle("basic_idle");
    check("basic_frame_cnt", 32'(frame_cnt), 32'd1);

    // Three-cycle source stall mid-line
    sv_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    start_frame(8, 2, 1, 3, 1, 1'b0);
    run_frame(8, 2, 1, 3, 1, -1, 1'b0);
    chk_idle("stall_idle");

    // Rejected starts: zero height, then width below one beat
    for (int t = 0; t < 2; t++) begin
      imageWidth  = (t == 0) ? CW'(8) : CW'(1);
      imageHeight = (t == 0) ? CW'(0) : CW'(2);
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      check("cfg_err_pulse", 32'({cfg_err, busy, Fval}), 32'b100);
      next_cycle();
      check("cfg_err_clear", 32'({cfg_err, busy, Fval}), 32'b000);
    end
    check("cfg_err_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Free-running three frames, stop during frame 3
    cont_mode = 1'b1;
    start_frame(6, 3, 2, 1, 2, 1'b0);
    run_frame(6, 3, 2, 1, 2, -1, 1'b0);
    run_frame(6, 3, 2, 1, 2, -1, 1'b0);
    run_frame(6, 3, 2, 1, 2, 1, 1'b0);
    chk_idle("cont_stop_idle");
    next_cycle();
    chk_idle("cont_stop_stays_idle");

    // start and stop in the same IDLE cycle: exactly one frame
    start_frame(4, 1, 0, 0, 0, 1'b1);
    run_frame(4, 1, 0, 0, 0, -1, 1'b0);
    chk_idle("start_stop_one_frame");

    // Random single frames, geometry and start scrambled mid-frame
    cont_mode   = 1'b0;
    g_stall_pct = 30;
    for (int n = 0; n < 8; n++) begin
      int w, h, hb, vb, fs;
      w  = int'($urandom_range(19, PPT));
      h  = int'($urandom_range(4, 1));
      hb = int'($urandom_range(3, 0));
      vb = int'($urandom_range(3, 0));
      fs = int'($urandom_range(3, 0));
      start_frame(w, h, hb, vb, fs, 1'b0);
      run_frame(w, h, hb, vb, fs, -1, 1'b1);
      chk_idle("rand_idle");
    end

    // Random free-running pair, stop in the second frame
    begin
      int w, h;
      w  = int'($urandom_range(13, PPT));
      h  = int'($urandom_range(3, 1));
      cont_mode = 1'b1;
      start_frame(w, h, 1, 2, 0, 1'b0);
      run_frame(w, h, 1, 2, 0, -1, 1'b0);
      run_frame(w, h, 1, 2, 0, int'($urandom_range(h - 1, 0)), 1'b0);
      chk_idle("rand_cont_idle");
      cont_mode = 1'b0;
    end

    // Reset in the middle of a line
    g_stall_pct = 0;
    start_frame(8, 2, 0, 0, 1, 1'b0);
    next_cycle();
    src_valid = 1'b1;
    next_cycle();
    check("rst_pre_line", 32'(Lval), 32'd1);
    sys_rst = 1'b1;
    next_cycle();
    sys_rst = 1'b0;
    exp_frames = 0;
    check("rst_outputs", 32'({Fval, Lval, pix_rdy, Dval, busy, frame_done, cfg_err}), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("rst_underrun", 32'(underrun_cnt), 32'd0);
    next_cycle();
    check("rst_no_frame_done", 32'({frame_done, busy}), 32'd0);
    src_valid = 1'b0;

    // Counter wrap on the narrow instance: 17 free-running frames
    k = 0;
    b_start = 1'b1;
    next_cycle();
    b_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (b_frame_done === 1'b1) begin
        k++;
        check("wrap_cnt", 32'(b_frame_cnt), 32'(k % 16));
        if (k == 17) begin
          b_stop = 1'b1;
          break;
        end
      end
      next_cycle();
    end
    check("wrap_frames", 32'(k), 32'd17);
    next_cycle();
    b_stop = 1'b0;
    check("wrap_idle", 32'({b_busy, b_fval, b_lval}), 32'd0);
    check("wrap_final_cnt", 32'(b_frame_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cl_timing_ctrl.md
CL_TIMING_CTRL -- requirements
Module: cl_timing_ctrl

Interface
REQ-001 SHALL have parameter PIX_PER_TAP, default 2, pixels per beat; legal values 1, 2, 4.
REQ-002 SHALL have parameter CW, default 16, width of geometry, blanking and counter fields.
REQ-003 SHALL have port pixel_clk  in  1  the only clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  pulse that requests a frame sequence.
REQ-006 SHALL have port stop  in  1  pulse that requests a graceful halt after the current frame.
REQ-007 SHALL have port cont_mode  in  1  1 = free-running back-to-back frames.
REQ-008 SHALL have port imageWidth  in  CW  pixels per line.
REQ-009 SHALL have port imageHeight  in  CW  lines per frame.
REQ-010 SHALL have port hblank  in  CW  idle cycles between lines.
REQ-011 SHALL have port vblank  in  CW  idle cycles between frames.
REQ-012 SHALL have port fv_setup  in  8  cycles from Fval rise to first Lval.
REQ-013 SHALL have port src_valid  in  1  pixel source presents one beat.
REQ-014 SHALL have port pix_rdy  out  1  controller accepts a beat this cycle.
REQ-015 SHALL have port Fval  out  1  CameraLink frame valid.
REQ-016 SHALL have port Lval  out  1  CameraLink line valid.
REQ-017 SHALL have port Dval  out  1  CameraLink data valid.
REQ-018 SHALL have port frame_cnt  out  CW  completed-frame count.
REQ-019 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-020 SHALL have port frame_done  out  1  one-cycle pulse at the end of each frame.
REQ-021 SHALL have port cfg_err  out  1  one-cycle pulse when a start is rejected.
REQ-022 SHALL have port underrun_cnt  out  CW  count of stalled line cycles.

Function
REQ-023 SHALL implement an FSM with states IDLE, SETUP, LINE, HBLANK and VBLANK.
REQ-024 SHALL latch imageWidth, imageHeight, hblank, vblank and fv_setup on each frame start (IDLE->SETUP or VBLANK->SETUP), and SHALL ignore input changes mid-frame.
REQ-025 SHALL compute beats per line as imageWidth / PIX_PER_TAP and SHALL discard any remainder bits.
REQ-026 SHALL, when start is seen in IDLE with imageWidth < PIX_PER_TAP or imageHeight == 0, stay in IDLE and pulse cfg_err for one cycle on the next cycle.
REQ-027 SHALL, when start is seen in IDLE with a valid configuration, enter SETUP on the next edge; Fval is registered and rises in that same cycle.
REQ-028 SHALL remain in SETUP for max(fv_setup,1) cycles, then enter LINE.
REQ-029 SHALL drive Lval = pix_rdy = 1 for every LINE cycle, and SHALL drive Dval = Lval & src_valid combinationally.
REQ-030 SHALL advance the beat counter only when pix_rdy & src_valid; when src_valid is low in LINE, Lval stays 1, Dval is 0 and the counters hold.
REQ-031 SHALL, on acceptance of the last beat of a non-final line, enter HBLANK for max(hblank,1) cycles with Lval=0 and Fval=1, then return to LINE.
REQ-032 SHALL, on acceptance of the last beat of the final line, enter VBLANK with Fval=Lval=0, pulse frame_done, and increment frame_cnt (wrapping 0xFFFF->0), all on the same cycle.
REQ-033 SHALL hold VBLANK for max(vblank,1) cycles, then enter SETUP if cont_mode=1 and no stop is pending, otherwise enter IDLE.
REQ-034 SHALL set a stop-pending flag on stop in any non-IDLE state, finish the current frame, and clear the flag on entry to IDLE; stop seen in IDLE has no effect.
REQ-035 SHALL ignore start in any non-IDLE state; start and stop seen in the same IDLE cycle start exactly one frame.

Reset
REQ-036 SHALL, when sys_rst=1 at an edge, enter IDLE and drive Fval, Lval, Dval, pix_rdy, busy, frame_done and cfg_err to 0, with frame_cnt, underrun_cnt, stop-pending and all internal counters cleared.
REQ-037 SHALL apply reset mid-frame with the same result, with no frame_done pulse.

Configuration
REQ-038 SHALL, with macro CL_UNDERRUN_CNT_EN defined, count in underrun_cnt the LINE cycles with src_valid=0, saturating at all-ones and clearing at each frame start.
REQ-039 SHALL, without CL_UNDERRUN_CNT_EN, tie underrun_cnt to 0 and instantiate no counter logic for it.

Verification
REQ-040 SHALL verify: width=8, height=2, hblank=1, vblank=3, fv_setup=1, src_valid=1 -> 4 Lval cycles per line, 1-cycle gap, frame_done once, frame_cnt=1, IDLE after 3 VBLANK cycles.
REQ-041 SHALL verify: src_valid low for 3 cycles mid-line -> Lval held, Dval=0 for those 3 cycles, line still exactly 4 beats, underrun_cnt=3 with the macro and 0 without it.
REQ-042 SHALL verify: start with imageHeight=0, and separately with imageWidth=1 -> cfg_err pulses once, busy stays 0, Fval stays 0.
REQ-043 SHALL verify: cont_mode=1 for 3 frames, then stop mid-frame 3 -> frame 3 completes, frame_cnt=3, then IDLE.
REQ-044 SHALL verify: sys_rst asserted mid-line -> all outputs 0 on the next cycle, frame_cnt=0, no frame_done pulse.
REQ-045 SHALL verify: frame_cnt preloaded to 0xFFFF by running 65535 frames in cont_mode, then one further frame -> frame_cnt wraps to 0.
